// File: rtl/filter_peak_detector.sv
// Purpose : threshold-crossing pulse detector on the shaped sample stream; reports
//           peak amplitude, peak timestamp and pulse width per qualified pulse.
// Latency : event valid 1 clock after the first not-above sample of a pulse.
// Backpr. : one-deep event register; an event issued while the held event is
//           stalled is dropped and counted in lost_count (saturating).
//
// Ports:
//   clk, reset (async active-low)
//   input_data, threshold   signed samples / detection level
//   enable                  detection enable (does not shorten holdoff)
//   peak_valid/peak_ready   event handshake towards readout
//   peak_amp/time/width     event payload, stable while peak_valid=1
//   lost_count              events dropped under backpressure
//   busy                    detector in ABOVE or HOLDOFF
module filter_peak_detector #(
  parameter int DATA_W    = 16,
  parameter int TS_W      = 32,
  parameter int HOLDOFF   = 16,
  parameter int MIN_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] input_data,
  input  logic signed [DATA_W-1:0] threshold,
  input  logic                     enable,
  input  logic                     peak_ready,
  output logic                     peak_valid,
  output logic signed [DATA_W-1:0] peak_amp,
  output logic        [TS_W-1:0]   peak_time,
  output logic        [15:0]       peak_width,
  output logic        [15:0]       lost_count,
  output logic                     busy
);

  // Holdoff counter sized to hold HOLDOFF itself.
  localparam int HCW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ABOVE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                    state;
  logic        [TS_W-1:0]    ts;
  logic signed [DATA_W-1:0]  max_val;
  logic        [TS_W-1:0]    max_time;
  logic        [15:0]        width;
  logic        [HCW-1:0]     hold_cnt;

  logic above;
  logic pulse_end;
  logic issue;
  logic transfer;

  always_comb begin
    above     = input_data > threshold;
    pulse_end = (state == S_ABOVE) && enable && !above;
    issue     = pulse_end && (int'(width) >= MIN_WIDTH);
    transfer  = peak_valid && peak_ready;
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      ts         <= '0;
      max_val    <= '0;
      max_time   <= '0;
      width      <= '0;
      hold_cnt   <= '0;
      peak_valid <= 1'b0;
      peak_amp   <= '0;
      peak_time  <= '0;
      peak_width <= '0;
      lost_count <= '0;
    end else begin
      // Free-running; the sample at this edge is tagged with the value before increment.
      ts <= ts + TS_W'(1);

      case (state)
        S_IDLE: begin
          if (enable && above) begin
            state    <= S_ABOVE;
            max_val  <= input_data;
            max_time <= ts;
            width    <= 16'd1;
          end
        end

        S_ABOVE: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (above) begin
            if (width != 16'hFFFF) width <= width + 16'd1;
            // Strict compare: on a plateau the earliest sample wins.
            if (input_data > max_val) begin
              max_val  <= input_data;
              max_time <= ts;
            end
          end else if (HOLDOFF == 0) begin
            state <= S_IDLE;
          end else begin
            state    <= S_HOLD;
            hold_cnt <= HCW'(HOLDOFF);
          end
        end

        S_HOLD: begin
          // Samples are ignored here regardless of enable.
          if (hold_cnt <= HCW'(1)) begin
            hold_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt - HCW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase

      // Output register: a pending transfer on this edge frees the slot for a new event.
      if (issue && (!peak_valid || peak_ready)) begin
        peak_valid <= 1'b1;
        peak_amp   <= max_val;
        peak_time  <= max_time;
        peak_width <= width;
      end else if (issue) begin
        if (lost_count != 16'hFFFF) lost_count <= lost_count + 16'd1;
      end else if (transfer) begin
        peak_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_filter_peak_detector.sv
module tb_filter_peak_detector;

  localparam int DW        = 16;
  localparam int TW        = 32;
  localparam int HOLDOFF   = 4;
  localparam int MIN_WIDTH = 2;

  logic                 clk;
  logic                 reset;
  logic signed [DW-1:0] input_data;
  logic signed [DW-1:0] threshold;
  logic                 enable;
  logic                 peak_ready;
  logic                 peak_valid;
  logic signed [DW-1:0] peak_amp;
  logic        [TW-1:0] peak_time;
  logic        [15:0]   peak_width;
  logic        [15:0]   lost_count;
  logic                 busy;

  filter_peak_detector #(
    .DATA_W(DW), .TS_W(TW), .HOLDOFF(HOLDOFF), .MIN_WIDTH(MIN_WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold),
    .enable(enable), .peak_ready(peak_ready), .peak_valid(peak_valid),
    .peak_amp(peak_amp), .peak_time(peak_time), .peak_width(peak_width),
    .lost_count(lost_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A pulse is kept as the list of its above-threshold samples; the event is
  // computed from that list when the pulse ends.
  int          pq[$];
  bit [31:0]   tq[$];
  bit          in_pulse;
  int          hold_left;
  bit [31:0]   ts_m;
  bit          m_vld;
  int          m_amp;
  bit [31:0]   m_time;
  int          m_wid;
  int          m_lost;
  bit          m_busy;

  task automatic model_reset();
    pq.delete(); tq.delete();
    in_pulse = 0; hold_left = 0; ts_m = 0;
    m_vld = 0; m_amp = 0; m_time = 0; m_wid = 0; m_lost = 0; m_busy = 0;
  endtask

  task automatic model_step(input int s, input int thr, input bit en, input bit rdy);
    bit        issue;
    bit        xfer;
    int        a;
    bit [31:0] t;
    int        w;
    issue = 0; a = 0; t = 0; w = 0;
    xfer  = m_vld && rdy;
    if (hold_left > 0) begin
      hold_left--;
    end else if (in_pulse) begin
      if (!en) begin
        in_pulse = 0; pq.delete(); tq.delete();
      end else if (s > thr) begin
        pq.push_back(s); tq.push_back(ts_m);
      end else begin
        if (pq.size() >= MIN_WIDTH) begin
          issue = 1;
          a = pq[0]; t = tq[0];
          foreach (pq[i]) if (pq[i] > a) begin a = pq[i]; t = tq[i]; end
          w = (pq.size() > 65535) ? 65535 : pq.size();
        end
        hold_left = HOLDOFF;
        in_pulse = 0; pq.delete(); tq.delete();
      end
    end else if (en && s > thr) begin
      in_pulse = 1; pq.push_back(s); tq.push_back(ts_m);
    end

    if (issue && (!m_vld || xfer)) begin
      m_vld = 1; m_amp = a; m_time = t; m_wid = w;
    end else if (issue) begin
      if (m_lost < 65535) m_lost++;
    end else if (xfer) begin
      m_vld = 0;
    end
    m_busy = in_pulse || (hold_left > 0);
    ts_m++;
  endtask

  task automatic cmp_model();
    chk("valid", peak_valid, m_vld);
    chk("lost_count", lost_count, m_lost);
    chk("busy", busy, m_busy);
    if (m_vld) begin
      chk("peak_amp", peak_amp, m_amp);
      chk("peak_time", peak_time, m_time);
      chk("peak_width", peak_width, m_wid);
    end
  endtask

  // Called at a falling edge: drive, advance model, clock, compare.
  task automatic step(input int smp, input bit rdy);
    input_data = DW'(smp);
    peak_ready = rdy;
    model_step(smp, int'(threshold), enable, rdy);
    @(posedge clk);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_valid", peak_valid, 0);
    chk("rst_amp", peak_amp, 0);
    chk("rst_time", peak_time, 0);
    chk("rst_width", peak_width, 0);
    chk("rst_lost", lost_count, 0);
    chk("rst_busy", busy, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int        smp;
    bit        rdy;
    bit        vld;
    int        amp;
    bit [31:0] tim;
    int        wid;
    bit        bsy;
  } vec_t;

  vec_t tbl[19];
  bit [31:0] t0;

  initial begin
    reset = 1'b0; input_data = '0; threshold = 16'sd100; enable = 1'b1; peak_ready = 1'b1;
    model_reset();

    // pulse 0,50,150,300,250,120,80 then holdoff; then a too-short pulse 200,50
    tbl[0]  = '{0,   1, 0, 0,   0, 0, 0};
    tbl[1]  = '{50,  1, 0, 0,   0, 0, 0};
    tbl[2]  = '{150, 1, 0, 0,   0, 0, 1};
    tbl[3]  = '{300, 1, 0, 0,   0, 0, 1};
    tbl[4]  = '{250, 1, 0, 0,   0, 0, 1};
    tbl[5]  = '{120, 1, 0, 0,   0, 0, 1};
    tbl[6]  = '{80,  1, 1, 300, 3, 4, 1};
    tbl[7]  = '{0,   1, 0, 0,   0, 0, 1};
    tbl[8]  = '{0,   1, 0, 0,   0, 0, 1};
    tbl[9]  = '{0,   1, 0, 0,   0, 0, 1};
    tbl[10] = '{0,   1, 0, 0,   0, 0, 0};
    tbl[11] = '{0,   1, 0, 0,   0, 0, 0};
    tbl[12] = '{200, 1, 0, 0,   0, 0, 1};
    tbl[13] = '{50,  1, 0, 0,   0, 0, 1};
    tbl[14] = '{0,   1, 0, 0,   0, 0, 1};
    tbl[15] = '{0,   1, 0, 0,   0, 0, 1};
    tbl[16] = '{0,   1, 0, 0,   0, 0, 1};
    tbl[17] = '{0,   1, 0, 0,   0, 0, 0};
    tbl[18] = '{0,   1, 0, 0,   0, 0, 0};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].smp, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), peak_valid, tbl[i].vld);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("tbl%0d_lost", i), lost_count, 0);
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_amp", i), peak_amp, tbl[i].amp);
        chk($sformatf("tbl%0d_time", i), peak_time, tbl[i].tim);
        chk($sformatf("tbl%0d_width", i), peak_width, tbl[i].wid);
      end
    end

    // ---- backpressure: second event dropped, first held stable ----
    t0 = ts_m + 1;
    step(150, 0); step(300, 0); step(50, 0);
    chk("bp_first_valid", peak_valid, 1);
    chk("bp_first_amp", peak_amp, 300);
    for (int i = 0; i < 17; i++) step(0, 0);
    step(200, 0); step(400, 0); step(0, 0);
    chk("bp_lost", lost_count, 1);
    chk("bp_held_amp", peak_amp, 300);
    chk("bp_held_time", peak_time, t0);
    chk("bp_held_width", peak_width, 2);
    step(0, 1);
    chk("bp_transfer_valid", peak_valid, 0);
    for (int i = 0; i < 5; i++) step(0, 1);
    chk("bp_no_second", peak_valid, 0);

    // ---- holdoff masks samples k+1..k+4 ----
    step(150, 1); step(150, 1); step(0, 1);
    for (int i = 0; i < HOLDOFF; i++) step(500, 1);
    chk("hold_ignored_valid", peak_valid, 0);
    chk("hold_busy_done", busy, 0);
    step(500, 1); step(500, 1); step(0, 1);
    chk("hold_second_amp", peak_amp, 500);
    chk("hold_second_width", peak_width, 2);
    for (int i = 0; i < 6; i++) step(0, 1);

    // ---- negative threshold, then plateau ----
    threshold = -16'sd10;
    t0 = ts_m;
    step(-5, 1); step(-5, 1); step(-20, 1);
    chk("neg_amp", peak_amp, -5);
    chk("neg_time", peak_time, t0);
    chk("neg_width", peak_width, 2);
    for (int i = 0; i < 5; i++) step(-20, 1);
    threshold = 16'sd100;
    t0 = ts_m;
    step(300, 1); step(300, 1); step(0, 1);
    chk("plateau_amp", peak_amp, 300);
    chk("plateau_time", peak_time, t0);
    for (int i = 0; i < 6; i++) step(0, 1);

    // ---- reset mid-pulse (lost_count is nonzero going in) ----
    step(150, 1); step(300, 1);
    do_reset();
    step(0, 1); step(0, 1); step(0, 1);
    chk("post_rst_no_event", peak_valid, 0);
    step(150, 1); step(200, 1); step(0, 1);
    chk("post_rst_ts", peak_time, 4);
    for (int i = 0; i < 6; i++) step(0, 1);

    // ---- randomized against the model ----
    for (int n = 0; n < 3000; n++) begin
      int  smp;
      bit  rdy;
      if ($urandom_range(0, 199) == 0) threshold = DW'($urandom_range(0, 200)) - 16'sd50;
      enable = ($urandom_range(0, 19) != 0);
      rdy    = ((n / 64) % 3 == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      smp    = int'($urandom_range(0, 600)) - 200;
      step(smp, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
